// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   - opcode constants (upper nibble of the instruction register)
//   - control-word bit indices and the ctrl_t type
//   - ALU flag bit indices
//   - cbit(): one-hot control word for a single bit index
package cpu_pkg;

    typedef logic [15:0] ctrl_t;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word bit positions
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    // ALU flag bit positions
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    function automatic ctrl_t cbit(input int idx);
        ctrl_t c;
        c      = '0;
        c[idx] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational lookup of {opcode, step, flags} -> control word.
//   opcode  in  4  instruction opcode (only meaningful from T2 on)
//   step    in  3  current micro-step
//   flags   in  2  registered ALU flags, [0]=zero [1]=carry
//   ctrl    out 16 raw control word (no reset/halt gating here)
// Steps beyond T4 decode to zero, so any NUM_STEPS in 5..8 works unchanged.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic [1:0]  flags,
    output logic [15:0] ctrl
);

    ctrl_t t2, t3, t4;

    // Execute-phase words for the decoded opcode
    always_comb begin
        t2 = '0;
        t3 = '0;
        t4 = '0;
        case (opcode)
            OP_LDA: begin
                t2 = cbit(CTRL_IO) | cbit(CTRL_MI);
                t3 = cbit(CTRL_RO) | cbit(CTRL_AI);
            end
            OP_ADD: begin
                t2 = cbit(CTRL_IO) | cbit(CTRL_MI);
                t3 = cbit(CTRL_RO) | cbit(CTRL_BI);
                t4 = cbit(CTRL_EO) | cbit(CTRL_AI) | cbit(CTRL_FI);
            end
            OP_SUB: begin
                t2 = cbit(CTRL_IO) | cbit(CTRL_MI);
                t3 = cbit(CTRL_RO) | cbit(CTRL_BI);
                t4 = cbit(CTRL_EO) | cbit(CTRL_SU) | cbit(CTRL_AI) | cbit(CTRL_FI);
            end
            OP_STA: begin
                t2 = cbit(CTRL_IO) | cbit(CTRL_MI);
                t3 = cbit(CTRL_AO) | cbit(CTRL_RI);
            end
            OP_LDI: t2 = cbit(CTRL_IO) | cbit(CTRL_AI);
            OP_JMP: t2 = cbit(CTRL_IO) | cbit(CTRL_J);
            // Flags are read live in T2; safe because FI never fires in T2.
            OP_JC:  if (flags[FLAG_C]) t2 = cbit(CTRL_IO) | cbit(CTRL_J);
            OP_JZ:  if (flags[FLAG_Z]) t2 = cbit(CTRL_IO) | cbit(CTRL_J);
            OP_OUT: t2 = cbit(CTRL_AO) | cbit(CTRL_OI);
            OP_HLT: t2 = cbit(CTRL_HLT);
            default: ;  // NOP and undefined opcodes: all-zero execute
        endcase
    end

    // Step select: common fetch, then execute, then zero padding
    always_comb begin
        ctrl = '0;
        case (step)
            3'd0: ctrl = cbit(CTRL_CO) | cbit(CTRL_MI);
            3'd1: ctrl = cbit(CTRL_RO) | cbit(CTRL_II) | cbit(CTRL_CE);
            3'd2: ctrl = t2;
            3'd3: ctrl = t3;
            3'd4: ctrl = t4;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit CPU.
//   NUM_STEPS        micro-steps per instruction, legal 5..8
//   clk      in  1   system clock
//   clear_n  in  1   asynchronous active-low reset
//   opcode   in  4   instruction register upper nibble
//   flags    in  2   registered ALU flags, [0]=zero [1]=carry
//   ctrl     out 16  control word (HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI)
//   step     out 3   current micro-step
//   halted   out 1   set once HLT has executed; only clear_n leaves it
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_STEPS = 5
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [3:0]  opcode,
    input  logic [1:0]  flags,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    ctrl_t rom_ctrl;

    microcode_rom u_rom (
        .opcode (opcode),
        .step   (step),
        .flags  (flags),
        .ctrl   (rom_ctrl)
    );

    // Step counter and halt flag. The HLT edge freezes step rather than
    // advancing it, so step keeps pointing at the halting micro-step.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            step   <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (rom_ctrl[CTRL_HLT]) begin
                halted <= 1'b1;
            end else if (step == LAST_STEP) begin
                step <= '0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

    // clear_n gates the word directly so no strobe leaks during reset,
    // and release is visible without waiting for an edge.
    always_comb begin
        ctrl = '0;
        if (!clear_n) begin
            ctrl = '0;
        end else if (halted) begin
            ctrl = cbit(CTRL_HLT);
        end else begin
            ctrl = rom_ctrl;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer (NUM_STEPS = 5).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or shortly after an asynchronous reset/flag change).
module tb_control_sequencer;

    logic        clk;
    logic        clear_n;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int n_vec;
    int n_err;

    control_sequencer #(.NUM_STEPS(5)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .opcode  (opcode),
        .flags   (flags),
        .ctrl    (ctrl),
        .step    (step),
        .halted  (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full instruction from T0 with the given opcode/flags, checking
    // ctrl and step at every micro-step and the wrap back to T0.
    task automatic run_instr(input string name, input logic [3:0] op, input logic [1:0] fl,
                             input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] exp_w [5];
        exp_w[0] = 16'h4004;
        exp_w[1] = 16'h1408;
        exp_w[2] = e2;
        exp_w[3] = e3;
        exp_w[4] = e4;
        opcode = op;
        flags  = fl;
        for (int t = 0; t < 5; t++) begin
            #1;
            chk($sformatf("%s T%0d step", name, t), {13'd0, step}, 16'(t));
            chk($sformatf("%s T%0d ctrl", name, t), ctrl, exp_w[t]);
            tick();
        end
        #1;
        chk($sformatf("%s wrap step", name), {13'd0, step}, 16'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        clear_n = 1'b0;
        opcode  = 4'hF;
        flags   = 2'b00;

        // Reset held for 3 cycles with HLT on the opcode bus
        repeat (3) tick();
        chk("reset ctrl", ctrl, 16'h0000);
        chk("reset step", {13'd0, step}, 16'd0);
        chk("reset halted", {15'd0, halted}, 16'd0);

        // Release: gating drops combinationally, fetch T0 visible
        clear_n = 1'b1;
        #1;
        chk("release ctrl", ctrl, 16'h4004);
        chk("release step", {13'd0, step}, 16'd0);

        run_instr("LDA", 4'h1, 2'b00, 16'h4800, 16'h1200, 16'h0000);
        run_instr("SUB", 4'h3, 2'b00, 16'h4800, 16'h1020, 16'h02C1);
        run_instr("ADD", 4'h2, 2'b11, 16'h4800, 16'h1020, 16'h0281);
        run_instr("STA", 4'h4, 2'b00, 16'h4800, 16'h2100, 16'h0000);
        run_instr("LDI", 4'h5, 2'b00, 16'h0A00, 16'h0000, 16'h0000);
        run_instr("JMP", 4'h6, 2'b00, 16'h0802, 16'h0000, 16'h0000);
        run_instr("JC taken", 4'h7, 2'b10, 16'h0802, 16'h0000, 16'h0000);
        run_instr("JC not", 4'h7, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        run_instr("JC zero only", 4'h7, 2'b01, 16'h0000, 16'h0000, 16'h0000);
        run_instr("JZ taken", 4'h8, 2'b01, 16'h0802, 16'h0000, 16'h0000);
        run_instr("JZ not", 4'h8, 2'b10, 16'h0000, 16'h0000, 16'h0000);
        run_instr("OUT", 4'hE, 2'b00, 16'h0110, 16'h0000, 16'h0000);
        run_instr("NOP", 4'h0, 2'b11, 16'h0000, 16'h0000, 16'h0000);
        run_instr("UNDEF", 4'hA, 2'b11, 16'h0000, 16'h0000, 16'h0000);

        // Flags changing during T2 of JC are followed combinationally
        opcode = 4'h7;
        flags  = 2'b00;
        tick();
        tick();
        #1;
        chk("JC live flags off", ctrl, 16'h0000);
        flags = 2'b10;
        #1;
        chk("JC live flags on", ctrl, 16'h0802);
        tick();
        tick();
        tick();
        #1;
        chk("JC live wrap step", {13'd0, step}, 16'd0);

        // HLT: T2 shows HLT, then frozen for 20 cycles
        opcode = 4'hF;
        flags  = 2'b00;
        tick();
        tick();
        #1;
        chk("HLT T2 ctrl", ctrl, 16'h8000);
        chk("HLT T2 halted", {15'd0, halted}, 16'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("HLT c%0d halted", c), {15'd0, halted}, 16'd1);
            chk($sformatf("HLT c%0d step", c), {13'd0, step}, 16'd2);
            chk($sformatf("HLT c%0d ctrl", c), ctrl, 16'h8000);
        end

        // Asynchronous reset while halted
        #2;
        clear_n = 1'b0;
        #1;
        chk("halt rst ctrl", ctrl, 16'h0000);
        chk("halt rst step", {13'd0, step}, 16'd0);
        chk("halt rst halted", {15'd0, halted}, 16'd0);
        tick();
        clear_n = 1'b1;
        #1;
        chk("halt rel ctrl", ctrl, 16'h4004);

        // Asynchronous reset during ADD T3
        opcode = 4'h2;
        tick();
        tick();
        tick();
        #1;
        chk("ADD T3 ctrl", ctrl, 16'h1020);
        #2;
        clear_n = 1'b0;
        #1;
        chk("ADD rst ctrl", ctrl, 16'h0000);
        chk("ADD rst step", {13'd0, step}, 16'd0);
        chk("ADD rst halted", {15'd0, halted}, 16'd0);
        tick();
        chk("ADD rst hold ctrl", ctrl, 16'h0000);
        clear_n = 1'b1;

        // Clean instruction after release
        run_instr("post LDA", 4'h1, 2'b00, 16'h4800, 16'h1200, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit CPU. Steps through fetch and execute micro-steps, decodes the instruction register opcode together with the registered flags from `alu8`, and drives the 16-bit control word that gates every bus driver and register load. Its outputs include `alu8`'s `load` (FI), `sum_out` (EO) and `subtract` (SU) strobes, and it consumes `alu8`'s `flags` for conditional jumps.

## Interface
- `NUM_STEPS`, default 5: micro-steps per instruction, legal range 5..8.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `clear_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  4: upper nibble of the instruction register.
- `flags`  in  2: registered ALU flags; [0] = zero, [1] = carry.
- `ctrl`  out  16: control word. Bit mapping: 15 HLT, 14 MI, 13 RI, 12 RO, 11 IO, 10 II, 9 AI, 8 AO, 7 EO, 6 SU, 5 BI, 4 OI, 3 CE, 2 CO, 1 J, 0 FI.
- `step`  out  3: current micro-step, for debug and display.
- `halted`  out  1: high once HLT has executed.

## Operation
- State: `step` counter (3 bits) and a `halted` flag. `ctrl` is combinational from `step`, `opcode`, `flags` and `halted`.
- Fetch, identical for all opcodes:
  - T0: CO|MI
  - T1: RO|II|CE
- Execute steps T2..T4:
  - LDA 0001: IO|MI ; RO|AI ; 0
  - ADD 0010: IO|MI ; RO|BI ; EO|AI|FI
  - SUB 0011: IO|MI ; RO|BI ; EO|SU|AI|FI
  - STA 0100: IO|MI ; AO|RI ; 0
  - LDI 0101: IO|AI ; 0 ; 0
  - JMP 0110: IO|J ; 0 ; 0
  - JC 0111: IO|J at T2 if `flags[1]`, else 0 ; 0 ; 0
  - JZ 1000: IO|J at T2 if `flags[0]`, else 0 ; 0 ; 0
  - OUT 1110: AO|OI ; 0 ; 0
  - HLT 1111: HLT ; 0 ; 0
- NOP 0000 and undefined opcodes 1001..1101 produce all-zero execute steps.
- Steps T5..T(NUM_STEPS-1), when present, are all zero.
- Step counter:
  - Increments each edge.
  - Wraps from NUM_STEPS-1 to 0; there is no early termination.
- Halt:
  - At the edge that ends a step with `ctrl[15]` set, `halted` is set and `step` freezes at its current value.
  - While `halted` is high, `ctrl` = 16'h8000 (HLT only).
  - Only `clear_n` leaves halt.
- Conditional jumps sample `flags` combinationally during T2. The flags reflect the last FI-qualified ALU operation.

## Timing
- Reset: while `clear_n` is low, `step` = 0, `halted` = 0 and `ctrl` = 16'h0000. `ctrl` is gated, so there are no spurious strobes during reset.
- First edge after `clear_n` rises: the design is in T0 with `ctrl` = CO|MI. Gating releases combinationally on deassertion.
- `ctrl` settles within the same cycle as the `step`/`opcode` change. Downstream registers capture on the next rising edge.
- `opcode` is guaranteed valid from T2. It may change during T1, since II loads at the end of T1. Its value in T0/T1 is ignored.
- Instruction latency: exactly NUM_STEPS cycles, HLT excepted.
- Reset mid-instruction (any step, halted or not): state returns immediately to T0/not-halted and `ctrl` = 0. No partial completion.
- `flags` changing during T2 of JC/JZ follows combinationally. This is legal only because FI never fires in T2.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_NOP … OP_HLT)
  - control bit index constants (CTRL_HLT … CTRL_FI)
  - `ctrl_t` 16-bit typedef
  - flag index constants FLAG_Z = 0, FLAG_C = 1
- Sub-module `microcode_rom`: purely combinational lookup of {opcode, step, flags} to `ctrl_t`.
- The top level holds the counter, halt flag, reset gating and halt override.

## Test plan
- Reset: hold `clear_n` low for 3 cycles with `opcode` = 1111 → `ctrl` = 0000, `step` = 0, `halted` = 0. After release → `ctrl` = 4004 (CO|MI).
- LDA: `opcode` = 0001 → `ctrl` per step T0..T4 = 4004, 1408, 4800, 1200, 0000. Then `step` wraps to 0.
- SUB: `opcode` = 0011 → T4 `ctrl` = 02C1 (AI|EO|SU|FI). ADD: `opcode` = 0010 → T4 `ctrl` = 0281.
- JC taken and not taken: `opcode` = 0111 at T2 with `flags` = 10 → `ctrl` = 0802. With `flags` = 00 → `ctrl` = 0000. JZ with `flags` = 01 → 0802.
- HLT: `opcode` = 1111 → T2 `ctrl` = 8000. From the next edge, `halted` = 1, `step` stays at 2 and `ctrl` stays 8000 for 20 cycles.
- Reset mid-operation: assert `clear_n` low asynchronously during ADD T3 and, separately, while halted → `ctrl` = 0 immediately, `step` = 0 and `halted` = 0 before the next edge. A clean fetch follows release.
